// File: rtl/ram_bist_ctrl.sv
// March C- style BIST controller (M0 W0 up; M1 R0,W1 up; M2 R1,W0 down; M3 R0 up).
// Define BIST_STOP_ON_FAIL_EN to end the run in the cycle after the first mismatch.
module ram_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_cnt
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, FLUSH, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = '0;
  localparam logic [DATA_WIDTH-1:0] ONES     = '1;
  localparam logic [DATA_WIDTH-1:0] ZEROS    = '0;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    phase_q, phase_d;       // 0 = read slot, 1 = write slot in M1/M2
  logic                    cmp_pend_q, cmp_pend_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic                    err_q, err_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]              fail_cnt_q, fail_cnt_d;
  logic                    we_c;
  logic                    read_issue;
  logic [DATA_WIDTH-1:0]   rd_exp;
  logic                    mismatch;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    phase_d     = phase_q;
    cmp_pend_d  = 1'b0;
    exp_d       = exp_q;
    cmp_addr_d  = cmp_addr_q;
    err_d       = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    we_c        = 1'b0;
    read_issue  = 1'b0;
    rd_exp      = ZEROS;

    // Data read in the previous cycle is checked against the registered expectation.
    mismatch = cmp_pend_q && (dout != exp_q);
    if (mismatch) begin
      err_d = 1'b1;
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
      if (fail_cnt_q == 8'd0)  fail_addr_d = cmp_addr_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = M0;
          addr_d      = ADDR_MIN;
          din_d       = ZEROS;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          fail_cnt_d  = 8'd0;
          fail_addr_d = '0;
        end
      end
      M0: begin
        we_c = 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = M1;
          addr_d  = ADDR_MIN;
          din_d   = ONES;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      M1: begin
        if (!phase_q) begin
          read_issue = 1'b1;
          rd_exp     = ZEROS;
          phase_d    = 1'b1;
        end else begin
          we_c    = 1'b1;
          phase_d = 1'b0;
          if (addr_q == ADDR_MAX) begin
            state_d = M2;
            addr_d  = ADDR_MAX;
            din_d   = ZEROS;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      M2: begin
        if (!phase_q) begin
          read_issue = 1'b1;
          rd_exp     = ONES;
          phase_d    = 1'b1;
        end else begin
          we_c    = 1'b1;
          phase_d = 1'b0;
          if (addr_q == ADDR_MIN) begin
            state_d = M3;
            addr_d  = ADDR_MIN;
          end else begin
            addr_d = addr_q - ADDR_WIDTH'(1);
          end
        end
      end
      M3: begin
        read_issue = 1'b1;
        rd_exp     = ZEROS;
        if (addr_q == ADDR_MAX) state_d = FLUSH;
        else                    addr_d  = addr_q + ADDR_WIDTH'(1);
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (read_issue) begin
      cmp_pend_d = 1'b1;
      exp_d      = rd_exp;
      cmp_addr_d = addr_q;
    end

`ifdef BIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_d    = DONE;
      addr_d     = addr_q;
      din_d      = din_q;
      phase_d    = 1'b0;
      cmp_pend_d = 1'b0;
    end
`endif

    if (state_d == DONE && state_q != DONE) pass_d = (fail_cnt_d == 8'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  // NOTE: every flop, including the compare datapath, is reset so an abandoned run leaves no stale compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      phase_q     <= 1'b0;
      cmp_pend_q  <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      err_q       <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      phase_q     <= phase_d;
      cmp_pend_q  <= cmp_pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign we        = we_c;
  assign addr      = addr_q;
  assign din       = din_q;
  assign busy      = (state_q inside {M0, M1, M2, M3, FLUSH});
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err       = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with stuck-at fault masks, run-level scoreboard.
// Expectations follow BIST_STOP_ON_FAIL_EN when the bench is built with that macro.
module tb_ram_bist_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy, done, pass, err;
  logic [AW-1:0] fail_addr;
  logic [7:0]    fail_cnt;

  logic [DW-1:0] mem [D];
  logic [DW-1:0] sa1 [D];
  logic [DW-1:0] sa0 [D];

  int errors = 0;
  int checks = 0;
  int err_seen = 0;

  typedef struct {
    string tag;
    int    cyc;
    logic  pass;
    int    cnt;
    int    faddr;
    int    errs;
  } exp_t;
  exp_t sb[$];

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .done(done), .pass(pass), .err(err),
    .fail_addr(fail_addr), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM; stuck-at masks corrupt the read path only.
  always @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= (mem[addr] | sa1[addr]) & ~sa0[addr];
  end

  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < D; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  task automatic run_bist(input string tag, input int ecyc, input logic epass, input int ecnt,
                          input int efaddr, input int eerrs, input int restart_at);
    exp_t e;
    int   cyc, e0, overlap, gaps, held_cnt;
    e.tag = tag; e.cyc = ecyc; e.pass = epass; e.cnt = ecnt; e.faddr = efaddr; e.errs = eerrs;
    sb.push_back(e);
    e0 = err_seen; overlap = 0; gaps = 0; cyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (cyc < 400 && done !== 1'b1) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (busy !== 1'b1 && done !== 1'b1) gaps++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_cycles"},    cyc,       e.cyc);
    check({e.tag, "_pass"},      pass,      e.pass);
    check({e.tag, "_fail_cnt"},  fail_cnt,  e.cnt);
    check({e.tag, "_fail_addr"}, fail_addr, e.faddr);
    check({e.tag, "_busy_off"},  busy,      1'b0);
    check({e.tag, "_we_off"},    we,        1'b0);
    check({e.tag, "_overlap"},   overlap,   0);
    check({e.tag, "_busy_gap"},  gaps,      0);
    held_cnt = fail_cnt;
    repeat (2) @(negedge clk);
    check({e.tag, "_done_held"}, done,      1'b1);
    check({e.tag, "_cnt_held"},  fail_cnt,  held_cnt);
    check({e.tag, "_err_pulses"}, err_seen - e0, e.errs);
  endtask

  initial begin
    clear_faults();
    #1;
    check("rst_we",   we, 1'b0);
    check("rst_addr", addr, 0);
    check("rst_din",  din, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err",  err, 1'b0);
    check("rst_faddr", fail_addr, 0);
    check("rst_fcnt", fail_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_bist("clean", 6*D+1, 1'b1, 0, 0, 0, -1);

    sa1[5] = 8'h01;
`ifdef BIST_STOP_ON_FAIL_EN
    run_bist("sa1_a5", 28, 1'b0, 1, 5, 1, -1);
`else
    run_bist("sa1_a5", 97, 1'b0, 2, 5, 2, -1);
`endif

    clear_faults();
    sa0[15] = 8'h08;
`ifdef BIST_STOP_ON_FAIL_EN
    run_bist("sa0_a15", 50, 1'b0, 1, 15, 1, -1);
`else
    run_bist("sa0_a15", 97, 1'b0, 1, 15, 1, -1);
`endif

    clear_faults();
    sa1[3] = 8'h01;
    sa0[9] = 8'h04;
`ifdef BIST_STOP_ON_FAIL_EN
    run_bist("two_faults", 24, 1'b0, 1, 3, 1, -1);
`else
    run_bist("two_faults", 97, 1'b0, 3, 3, 3, -1);
`endif

    clear_faults();
    run_bist("restart_ignored", 97, 1'b1, 0, 0, 0, 40);

    // Abandon a faulty run during M2 with a one-cycle reset.
    sa1[5] = 8'h01;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_fail_cnt",  fail_cnt, 1);
    check("mid_fail_addr", fail_addr, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",    we, 1'b0);
    check("mid_rst_addr",  addr, 0);
    check("mid_rst_din",   din, 0);
    check("mid_rst_busy",  busy, 1'b0);
    check("mid_rst_done",  done, 1'b0);
    check("mid_rst_pass",  pass, 1'b0);
    check("mid_rst_err",   err, 1'b0);
    check("mid_rst_faddr", fail_addr, 0);
    check("mid_rst_fcnt",  fail_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_done", done, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_we",   we, 1'b0);
    clear_faults();
    run_bist("after_reset", 97, 1'b1, 0, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: RAM address width, depth D = 2^ADDR_WIDTH.
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge; one clock, reset asynchronous active-low.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have start  input  1  one-cycle request to begin a test run.
REQ-006 SHALL have we  output  1  RAM write enable.
REQ-007 SHALL have addr  output  ADDR_WIDTH  RAM address.
REQ-008 SHALL have din  output  DATA_WIDTH  RAM write data.
REQ-009 SHALL have dout  input  DATA_WIDTH  RAM read data, valid one cycle after a read is issued.
REQ-010 SHALL have busy  output  1  test run in progress.
REQ-011 SHALL have done  output  1  run finished, held until next accepted start.
REQ-012 SHALL have pass  output  1  valid while done=1; 1 = zero mismatches.
REQ-013 SHALL have err  output  1  one-cycle pulse per detected mismatch.
REQ-014 SHALL have fail_addr  output  ADDR_WIDTH  address of first mismatch in current run.
REQ-015 SHALL have fail_cnt  output  8  mismatch count, saturating at 255.

Function
REQ-016 SHALL run March sequence M0 W0 ascending; M1 R0,W1 ascending; M2 R1,W0 descending; M3 R0 ascending; "0" = all-zeros word, "1" = all-ones word.
REQ-017 SHALL use FSM states IDLE, M0, M1, M2, M3, FLUSH, DONE; IDLE->M0 on start, Mk->Mk+1 after last address of element, M3->FLUSH->DONE, DONE->M0 on start.
REQ-018 SHALL spend 1 cycle per address in M0/M3 (write or read only) and 2 cycles per address in M1/M2 (read cycle with we=0, then write cycle with we=1 to same address).
REQ-019 SHALL compare dout against expected value in the cycle after each read issue, using registered expected data and address; FLUSH covers the final M3 compare.
REQ-020 SHALL complete a clean run in 6*D+1 cycles after start is sampled (97 for D=16), then assert done.
REQ-021 SHALL drive busy=1 from the cycle after start is sampled until the cycle done rises; busy and done never both 1.
REQ-022 SHALL on mismatch pulse err, increment fail_cnt (saturate 255), capture fail_addr only on first mismatch of the run.
REQ-023 SHALL set pass = (fail_cnt==0) when entering DONE.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL on accepted start clear done, pass, fail_cnt, fail_addr in the same edge.
REQ-026 SHALL drive we=0 in IDLE, FLUSH, DONE; addr and din hold last value outside active cycles.
REQ-027 SHALL wrap address counter without overflow at D-1 (ascending) and 0 (descending) by element termination, never by counter rollover.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE and we=0, addr=0, din=0, busy=0, done=0, pass=0, err=0, fail_addr=0, fail_cnt=0.
REQ-029 SHALL on reset mid-run abandon the run with no done and no pending compare; next start begins a full fresh run.

Configuration
REQ-030 SHALL with macro BIST_STOP_ON_FAIL_EN defined go to DONE in the cycle after the first mismatch (pass=0, fail_cnt=1); without it, complete all elements and count every mismatch.

Verification
REQ-031 SHALL cover: ideal RAM D=16, start pulse -> done after 97 cycles, pass=1, fail_cnt=0, err never asserted.
REQ-032 SHALL cover: bit0 of addr 5 stuck-at-1, macro undefined -> err pulses in M1 and M3 at addr 5, fail_cnt=2, fail_addr=5, pass=0.
REQ-033 SHALL cover: same fault, BIST_STOP_ON_FAIL_EN defined -> done one cycle after M1 read compare of addr 5, fail_cnt=1, fail_addr=5.
REQ-034 SHALL cover: rst_n low for 1 cycle during M2 -> all outputs at reset values, we=0; new start on clean RAM gives pass=1 after 97 cycles.
REQ-035 SHALL cover: start pulsed again at cycle 40 of a run -> ignored, run still ends at cycle 97 with unchanged results.
